// File: rtl/bldc_pkg.sv
// ---------------------------------------------------------------------------
// bldc_pkg
// Shared definitions for the BLDC PWM gate driver:
//   - sector encoding constants (SEC_INVALID, SEC_1..SEC_6)
//   - switching-mode constants (MODE_UNIPOLAR, MODE_COMPL)
//   - Hall-code to sector lookup
//   - per-sector forward high/low phase masks, bit order {C,B,A}
// ---------------------------------------------------------------------------
package bldc_pkg;

    localparam logic [2:0] SEC_INVALID = 3'd0;
    localparam logic [2:0] SEC_1       = 3'd1;
    localparam logic [2:0] SEC_2       = 3'd2;
    localparam logic [2:0] SEC_3       = 3'd3;
    localparam logic [2:0] SEC_4       = 3'd4;
    localparam logic [2:0] SEC_5       = 3'd5;
    localparam logic [2:0] SEC_6       = 3'd6;

    localparam logic MODE_UNIPOLAR = 1'b0;
    localparam logic MODE_COMPL    = 1'b1;

    // Forward-direction phase roles for one sector: 'high' marks the phase
    // that is switched to the positive rail, 'low' the phase tied to the
    // negative rail. The remaining phase floats.
    typedef struct packed {
        logic [2:0] high;
        logic [2:0] low;
    } phase_mask_t;

    // Hall {C,B,A} to 6-step sector. 000 and 111 cannot occur with healthy
    // sensors and map to the invalid sector.
    function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
        case (code)
            3'b001:  return SEC_1;
            3'b011:  return SEC_2;
            3'b010:  return SEC_3;
            3'b110:  return SEC_4;
            3'b100:  return SEC_5;
            3'b101:  return SEC_6;
            default: return SEC_INVALID;
        endcase
    endfunction

    // Forward phase pairs: 1 A+B-, 2 A+C-, 3 B+C-, 4 B+A-, 5 C+A-, 6 C+B-.
    function automatic phase_mask_t sector_masks(input logic [2:0] sec);
        phase_mask_t m;
        m = '{high: 3'b000, low: 3'b000};
        case (sec)
            SEC_1:   m = '{high: 3'b001, low: 3'b010};
            SEC_2:   m = '{high: 3'b001, low: 3'b100};
            SEC_3:   m = '{high: 3'b010, low: 3'b100};
            SEC_4:   m = '{high: 3'b010, low: 3'b001};
            SEC_5:   m = '{high: 3'b100, low: 3'b001};
            SEC_6:   m = '{high: 3'b100, low: 3'b010};
            default: m = '{high: 3'b000, low: 3'b000};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bldc_pwm_driver_dead_time_gen.sv
// ---------------------------------------------------------------------------
// dead_time_gen
// Per-phase request-to-gate stage. In complementary mode a gate may only
// turn on once its partner has been off for dead_cycles clk; turn-off is
// always immediate. In unipolar mode the requests pass straight through.
// The two gates are never on together, whatever the requests.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   compl           1 = apply dead time (complementary switching)
//   dead_cycles     required partner-off time in clk cycles
//   req_h, req_l    requested high/low gate state
//   gate_h, gate_l  gate outputs
// ---------------------------------------------------------------------------
module dead_time_gen
    import bldc_pkg::*;
#(
    parameter int DEAD_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              compl,
    input  logic [DEAD_W-1:0] dead_cycles,
    input  logic              req_h,
    input  logic              req_l,
    output logic              gate_h,
    output logic              gate_l
);

    logic [DEAD_W-1:0] h_off_cnt;
    logic [DEAD_W-1:0] l_off_cnt;
    logic              h_allow;
    logic              l_allow;

    // The off counters hold how many preceding cycles each gate has been
    // off, so a gate that drops this cycle reads as 0 and its partner waits
    // the full dead_cycles before turning on.
    assign h_allow = (compl != MODE_COMPL) || (l_off_cnt >= dead_cycles);
    assign l_allow = (compl != MODE_COMPL) || (h_off_cnt >= dead_cycles);

    // Contradictory requests turn both gates off rather than risk
    // shoot-through.
    assign gate_h = req_h & ~req_l & h_allow;
    assign gate_l = req_l & ~req_h & l_allow;

    // Saturating off-time counters, cleared whenever their gate is on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_off_cnt <= '0;
            l_off_cnt <= '0;
        end else begin
            if (gate_h)
                h_off_cnt <= '0;
            else if (h_off_cnt != '1)
                h_off_cnt <= h_off_cnt + DEAD_W'(1);

            if (gate_l)
                l_off_cnt <= '0;
            else if (l_off_cnt != '1)
                l_off_cnt <= l_off_cnt + DEAD_W'(1);
        end
    end

endmodule

// File: rtl/bldc_pwm_driver.sv
// ---------------------------------------------------------------------------
// bldc_pwm_driver
// BLDC gate driver: synchronises the Hall inputs, decodes the 6-step sector,
// generates an edge-aligned PWM carrier and drives three high/low gate
// pairs in unipolar or complementary mode with dead time and commutation
// blanking.
// Build option: define HALL_FILTER_EN to accept a synchronised Hall code
// only after FILT_LEN identical consecutive samples.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   enable        1 = drive gates, 0 = gates off and hall_fault clearable
//   mode          0 = unipolar independent, 1 = complementary
//   dir           0 = forward, 1 = reverse
//   duty          requested duty, loaded at carrier wrap
//   dead_cycles   dead time and commutation blanking length in clk
//   hall          raw asynchronous Hall {C,B,A}
//   gate_h/gate_l high/low side gates {C,B,A}
//   sector        current sector 1..6, 0 = invalid
//   hall_fault    sticky invalid-Hall flag
//   pwm_sync      one-clk pulse when the carrier wraps
// ---------------------------------------------------------------------------
module bldc_pwm_driver
    import bldc_pkg::*;
#(
    parameter int DWIDTH   = 10,
    parameter int PRESCALE = 2,
    parameter int DEAD_W   = 6,
    parameter int FILT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              mode,
    input  logic              dir,
    input  logic [DWIDTH-1:0] duty,
    input  logic [DEAD_W-1:0] dead_cycles,
    input  logic [2:0]        hall,
    output logic [2:0]        gate_h,
    output logic [2:0]        gate_l,
    output logic [2:0]        sector,
    output logic              hall_fault,
    output logic              pwm_sync
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [2:0]        hall_s1;
    logic [2:0]        hall_s2;
    logic [1:0]        sync_valid;
    logic [2:0]        code;
    logic              code_valid;
    logic [2:0]        decoded;

    logic [PW-1:0]     presc;
    logic              tick;
    logic              wrap;
    logic [DWIDTH-1:0] counter;
    logic [DWIDTH-1:0] shadow_duty;
    logic              pwm;

    logic [5:0]        key_now;
    logic [5:0]        key_prev;
    logic              key_change;
    logic [DEAD_W-1:0] blank_cnt;
    logic              blanking;

    phase_mask_t       masks;
    logic [2:0]        plus_ph;
    logic [2:0]        minus_ph;
    logic              drive_ok;
    logic [2:0]        req_h;
    logic [2:0]        req_l;

    // Two-flop synchroniser for the asynchronous Hall lines. sync_valid
    // tracks when the pipeline holds real samples so the reset zeros are
    // not mistaken for an invalid 000 Hall code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hall_s1    <= '0;
            hall_s2    <= '0;
            sync_valid <= '0;
        end else begin
            hall_s1    <= hall;
            hall_s2    <= hall_s1;
            sync_valid <= {sync_valid[0], 1'b1};
        end
    end

`ifdef HALL_FILTER_EN
    localparam int FCW = $clog2(FILT_LEN + 1);

    logic [2:0]     hall_last;
    logic [2:0]     hall_filt;
    logic           filt_valid;
    logic [FCW-1:0] stable_cnt;
    logic [FCW-1:0] stable_next;

    // Length of the current run of identical synchronised samples,
    // including the one being taken this cycle, saturating at FILT_LEN.
    always_comb begin
        stable_next = FCW'(1);
        if (hall_s2 == hall_last) begin
            if (stable_cnt == FCW'(FILT_LEN))
                stable_next = stable_cnt;
            else
                stable_next = stable_cnt + FCW'(1);
        end
    end

    // A code is accepted once it has been seen FILT_LEN times in a row;
    // shorter glitches never reach the decoder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hall_last  <= '0;
            hall_filt  <= '0;
            filt_valid <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_valid[1]) begin
            hall_last  <= hall_s2;
            stable_cnt <= stable_next;
            if (stable_next == FCW'(FILT_LEN)) begin
                hall_filt  <= hall_s2;
                filt_valid <= 1'b1;
            end
        end
    end

    assign code       = hall_filt;
    assign code_valid = filt_valid;
`else
    logic unused_filt_len;

    assign unused_filt_len = |FILT_LEN;
    assign code            = hall_s2;
    assign code_valid      = sync_valid[1];
`endif

    assign decoded = hall_to_sector(code);

    // Registered sector decode and sticky fault. The fault only clears
    // while the drive is disabled and the Hall code is healthy again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sector     <= SEC_INVALID;
            hall_fault <= 1'b0;
        end else if (code_valid) begin
            sector <= decoded;
            if (decoded == SEC_INVALID)
                hall_fault <= 1'b1;
            else if (!enable)
                hall_fault <= 1'b0;
        end
    end

    assign tick = (presc == PW'(PRESCALE - 1));
    assign wrap = tick && (counter == '1);
    assign pwm  = (counter < shadow_duty);

    // Edge-aligned carrier: the prescaler produces one PWM tick every
    // PRESCALE clk; the duty shadow loads on the same edge the counter
    // wraps so a period never mixes two duty values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc       <= '0;
            counter     <= '0;
            shadow_duty <= '0;
            pwm_sync    <= 1'b0;
        end else begin
            presc    <= tick ? '0 : presc + PW'(1);
            pwm_sync <= wrap;
            if (tick)
                counter <= counter + DWIDTH'(1);
            if (wrap)
                shadow_duty <= duty;
        end
    end

    // Anything that changes the commutation pattern (sector, mode, dir or
    // enable) is detected combinationally so the gates drop in the very
    // cycle the change is visible.
    assign key_now    = {enable, dir, mode, sector};
    assign key_change = (key_now != key_prev);
    assign blanking   = (key_change && (dead_cycles != '0)) || (blank_cnt != '0);

    // Blanking counter: the change cycle itself is the first blank cycle,
    // so dead_cycles-1 further cycles remain. A change mid-blank restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_prev  <= '0;
            blank_cnt <= '0;
        end else begin
            key_prev <= key_now;
            if (key_change)
                blank_cnt <= (dead_cycles == '0) ? '0 : dead_cycles - DEAD_W'(1);
            else if (blank_cnt != '0)
                blank_cnt <= blank_cnt - DEAD_W'(1);
        end
    end

    assign masks    = sector_masks(sector);
    assign plus_ph  = dir ? masks.low  : masks.high;
    assign minus_ph = dir ? masks.high : masks.low;
    assign drive_ok = enable && !hall_fault && !blanking && (sector != SEC_INVALID);

    // Gate requests: the + phase chops with pwm (and in complementary mode
    // its low side takes the inverse), the - phase low side is held on.
    always_comb begin
        req_h = 3'b000;
        req_l = 3'b000;
        if (drive_ok) begin
            req_h = plus_ph & {3{pwm}};
            req_l = minus_ph;
            if (mode == MODE_COMPL)
                req_l = minus_ph | (plus_ph & {3{~pwm}});
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_phase
        dead_time_gen #(
            .DEAD_W(DEAD_W)
        ) u_dead_time_gen (
            .clk        (clk),
            .rst        (rst),
            .compl      (mode),
            .dead_cycles(dead_cycles),
            .req_h      (req_h[i]),
            .req_l      (req_l[i]),
            .gate_h     (gate_h[i]),
            .gate_l     (gate_l[i])
        );
    end

endmodule
